// File: rtl/ox_tl_pkg.sv
// Shared TileLink encodings for the OX manager: grow/cap params, grant FSM states, ID width.
package ox_tl_pkg;

    localparam int TL_ID_W = 26;

    localparam logic [2:0] TL_NTOB = 3'd0;
    localparam logic [2:0] TL_NTOT = 3'd1;
    localparam logic [2:0] TL_BTOT = 3'd2;

    localparam logic [1:0] TL_CAP_TOT = 2'd0;
    localparam logic [1:0] TL_CAP_TOB = 2'd1;

    typedef enum logic [2:0] {
        GR_IDLE    = 3'b001,
        GR_GNT_GEN = 3'b010,
        GR_DONE    = 3'b100
    } gr_state_e;

    // Only NtoB ends in Branch; NtoT, BtoT and reserved encodings all end in Trunk.
    function automatic logic [1:0] grow_to_cap(input logic [2:0] grow);
        return (grow == TL_NTOB) ? TL_CAP_TOB : TL_CAP_TOT;
    endfunction

endpackage

// File: rtl/tl_gnt_rsp_sm_if.sv
// Acquire / Grant / GrantAck signal bundle between OXmgr RX, TL TX and the grant responder.
interface tl_gnt_rsp_sm_if
    import ox_tl_pkg::*;
#(
    parameter int NUM_SINK = 4
);
    logic                 rx2tx_rcv_tlacq;
    logic [TL_ID_W-1:0]   a_source;
    logic [2:0]           a_param;
    logic                 tx2rx_rcv_tlacq_ack;
    logic                 grant_gen_en;
    logic                 grant_gen_done;
    logic [TL_ID_W-1:0]   d_sink;
    logic [TL_ID_W-1:0]   d_source;
    logic [1:0]           d_param;
    logic                 rx2tx_rcv_tlgntack;
    logic [TL_ID_W-1:0]   e_sink;
    logic                 tx2rx_rcv_tlgntack_ack;
    logic                 e_sink_err;
    logic [NUM_SINK-1:0]  sink_busy;
    logic                 sink_full;
    logic                 gnt_tmo_err;

    modport slave (
        input  rx2tx_rcv_tlacq, a_source, a_param, grant_gen_done, rx2tx_rcv_tlgntack, e_sink,
        output tx2rx_rcv_tlacq_ack, grant_gen_en, d_sink, d_source, d_param,
               tx2rx_rcv_tlgntack_ack, e_sink_err, sink_busy, sink_full, gnt_tmo_err
    );

    modport master (
        output rx2tx_rcv_tlacq, a_source, a_param, grant_gen_done, rx2tx_rcv_tlgntack, e_sink,
        input  tx2rx_rcv_tlacq_ack, grant_gen_en, d_sink, d_source, d_param,
               tx2rx_rcv_tlgntack_ack, e_sink_err, sink_busy, sink_full, gnt_tmo_err
    );

endinterface

// File: rtl/tl_sink_alloc.sv
// Sink slot bitmap (reserved / granted) with lowest-free pick and full flag.
// Latency: alloc/grant/free take effect on the next clk; pick and full come from registered state only.
// Backpressure: none internally; o_full is what holds off new Acquires.
module tl_sink_alloc
    import ox_tl_pkg::*;
#(
    parameter  int NUM_SINK = 4,
    localparam int IDX_W    = $clog2(NUM_SINK)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_alloc,
    output logic [IDX_W-1:0]    o_alloc_idx,
    input  logic                i_grant,
    input  logic [IDX_W-1:0]    i_grant_idx,
    input  logic [NUM_SINK-1:0] i_free,
    output logic [NUM_SINK-1:0] o_busy,
    output logic [NUM_SINK-1:0] o_granted,
    output logic                o_full
);
    logic [NUM_SINK-1:0] r_rsv;
    logic [NUM_SINK-1:0] r_gnt;
    logic [NUM_SINK-1:0] w_rsv_nxt;
    logic [NUM_SINK-1:0] w_gnt_nxt;

    assign o_busy    = r_rsv | r_gnt;
    assign o_granted = r_gnt;
    assign o_full    = &o_busy;

    // Walk from the top so the lowest free index is the last one written.
    always_comb begin
        o_alloc_idx = '0;
        for (int i = NUM_SINK - 1; i >= 0; i--) begin
            if (!o_busy[i]) o_alloc_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_rsv_nxt = r_rsv;
        w_gnt_nxt = r_gnt & ~i_free;
        if (i_alloc) w_rsv_nxt[o_alloc_idx] = 1'b1;
        if (i_grant) begin
            w_rsv_nxt[i_grant_idx] = 1'b0;
            w_gnt_nxt[i_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsv <= '0;
            r_gnt <= '0;
        end else begin
            r_rsv <= w_rsv_nxt;
            r_gnt <= w_gnt_nxt;
        end
    end

endmodule

// File: rtl/tl_gnt_rsp_sm.sv
// Manager-side Acquire -> Grant -> GrantAck responder; optional GrantAck timeout under TL_GNT_TMO_EN.
// Latency: Acquire ack and Grant request 1 clk after accept; GrantAck ack/err 1 clk after the pulse.
// Backpressure: Acquire left unacked (held by RX) while busy in a handshake or all sink slots are in use.
module tl_gnt_rsp_sm
    import ox_tl_pkg::*;
#(
    parameter int                 NUM_SINK  = 4,
    parameter logic [TL_ID_W-1:0] SINK_BASE = '0,
    parameter int                 TMO_CYC   = 4096
) (
    input  logic           clk,
    input  logic           reset,
    tl_gnt_rsp_sm_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SINK);

    gr_state_e           r_state;
    gr_state_e           w_state_nxt;
    logic                w_accept;
    logic                w_grant;
    logic [IDX_W-1:0]    w_alloc_idx;
    logic [IDX_W-1:0]    r_cur_idx;
    logic [NUM_SINK-1:0] w_busy;
    logic [NUM_SINK-1:0] w_granted;
    logic [NUM_SINK-1:0] w_ack_free;
    logic [NUM_SINK-1:0] w_tmo_hit;
    logic [NUM_SINK-1:0] w_free;
    logic                w_full;
    logic [TL_ID_W-1:0]  w_e_off;
    logic [IDX_W-1:0]    w_e_idx;
    logic                w_match;
    logic                w_miss;

    logic                r_acq_ack;
    logic                r_gnt_en;
    logic [TL_ID_W-1:0]  r_d_sink;
    logic [TL_ID_W-1:0]  r_d_source;
    logic [1:0]          r_d_param;
    logic                r_gntack_ack;
    logic                r_esink_err;

    tl_sink_alloc #(
        .NUM_SINK (NUM_SINK)
    ) u_alloc (
        .clk         (clk),
        .reset       (reset),
        .i_alloc     (w_accept),
        .o_alloc_idx (w_alloc_idx),
        .i_grant     (w_grant),
        .i_grant_idx (r_cur_idx),
        .i_free      (w_free),
        .o_busy      (w_busy),
        .o_granted   (w_granted),
        .o_full      (w_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_grant     = 1'b0;
        unique case (r_state)
            GR_IDLE: begin
                if (bus.rx2tx_rcv_tlacq && !w_full) begin
                    w_accept    = 1'b1;
                    w_state_nxt = GR_GNT_GEN;
                end
            end
            GR_GNT_GEN: begin
                if (bus.grant_gen_done) begin
                    w_grant     = 1'b1;
                    w_state_nxt = GR_DONE;
                end
            end
            GR_DONE:  w_state_nxt = GR_IDLE;
            default:  w_state_nxt = GR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= GR_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Unsigned wrap makes IDs below SINK_BASE land far out of range.
    assign w_e_off    = bus.e_sink - SINK_BASE;
    assign w_e_idx    = w_e_off[IDX_W-1:0];
    assign w_match    = bus.rx2tx_rcv_tlgntack && (w_e_off < TL_ID_W'(NUM_SINK)) && w_granted[w_e_idx];
    assign w_miss     = bus.rx2tx_rcv_tlgntack && !w_match;
    assign w_ack_free = w_match ? (NUM_SINK'(1) << w_e_idx) : '0;

`ifdef TL_GNT_TMO_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] r_tmo_cnt [NUM_SINK];
    logic             r_tmo_err;

    // A GrantAck landing on the expiry cycle takes priority over the timeout.
    always_comb begin
        w_tmo_hit = '0;
        for (int i = 0; i < NUM_SINK; i++) begin
            w_tmo_hit[i] = w_granted[i] && !w_ack_free[i] && (r_tmo_cnt[i] == CNT_W'(TMO_CYC - 1));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SINK; i++) begin
            if (reset)                                          r_tmo_cnt[i] <= '0;
            else if (w_grant && (r_cur_idx == IDX_W'(i)))       r_tmo_cnt[i] <= '0;
            else if (w_granted[i])                              r_tmo_cnt[i] <= r_tmo_cnt[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_tmo_err <= 1'b0;
        else       r_tmo_err <= |w_tmo_hit;
    end

    assign bus.gnt_tmo_err = r_tmo_err;
`else
    assign w_tmo_hit       = '0;
    assign bus.gnt_tmo_err = 1'b0;
`endif

    assign w_free = w_ack_free | w_tmo_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acq_ack    <= 1'b0;
            r_gnt_en     <= 1'b0;
            r_d_sink     <= '0;
            r_d_source   <= '0;
            r_d_param    <= '0;
            r_cur_idx    <= '0;
            r_gntack_ack <= 1'b0;
            r_esink_err  <= 1'b0;
        end else begin
            r_acq_ack    <= w_accept;
            r_gntack_ack <= w_match;
            r_esink_err  <= w_miss;
            if (w_accept) begin
                r_gnt_en   <= 1'b1;
                r_d_sink   <= SINK_BASE + TL_ID_W'(w_alloc_idx);
                r_d_source <= bus.a_source;
                r_d_param  <= grow_to_cap(bus.a_param);
                r_cur_idx  <= w_alloc_idx;
            end else if (w_grant) begin
                r_gnt_en   <= 1'b0;
            end
        end
    end

    assign bus.tx2rx_rcv_tlacq_ack    = r_acq_ack;
    assign bus.grant_gen_en           = r_gnt_en;
    assign bus.d_sink                 = r_d_sink;
    assign bus.d_source               = r_d_source;
    assign bus.d_param                = r_d_param;
    assign bus.tx2rx_rcv_tlgntack_ack = r_gntack_ack;
    assign bus.e_sink_err             = r_esink_err;
    assign bus.sink_busy              = w_busy;
    assign bus.sink_full              = w_full;

endmodule

// File: tb/tb_tl_gnt_rsp_sm.sv
// Bench for tl_gnt_rsp_sm: directed Acquire/Grant/GrantAck scenarios checked against a slot-level model every cycle.
module tb_tl_gnt_rsp_sm;
    localparam int          NS   = 4;
    localparam logic [25:0] BASE = 26'h100;
    localparam int          TMO  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tl_gnt_rsp_sm_if #(.NUM_SINK(NS)) bus ();

    tl_gnt_rsp_sm #(
        .NUM_SINK  (NS),
        .SINK_BASE (BASE),
        .TMO_CYC   (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slot-level model: 0 free, 1 reserved, 2 granted.
    int          m_st  [NS];
    int          m_age [NS];
    int          t_old [NS];
    bit          m_valid = 1'b0;
    bit          m_inflight, m_cool;
    int          m_cur, t_nbusy, t_pick;
    bit          t_acc, t_gd, t_hit;
    logic [25:0] t_off;
    logic        e_acq_ack, e_gen_en, e_gack, e_err, e_tmo;
    logic [25:0] e_dsink, e_dsrc;
    logic [1:0]  e_dparam;

    function automatic logic [NS-1:0] m_busy();
        logic [NS-1:0] b;
        for (int i = 0; i < NS; i++) b[i] = (m_st[i] != 0);
        return b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1; m_inflight = 1'b0; m_cool = 1'b0; m_cur = 0;
            for (int i = 0; i < NS; i++) begin m_st[i] = 0; m_age[i] = 0; end
            e_acq_ack = 0; e_gen_en = 0; e_gack = 0; e_err = 0; e_tmo = 0;
            e_dsink = '0; e_dsrc = '0; e_dparam = '0;
        end else if (m_valid) begin
            t_old = m_st;
            t_nbusy = 0; t_pick = -1;
            for (int i = NS - 1; i >= 0; i--) begin
                if (t_old[i] != 0) t_nbusy++;
                else               t_pick = i;
            end
            t_acc = bus.rx2tx_rcv_tlacq && !m_inflight && !m_cool && (t_nbusy < NS);
            t_gd  = m_inflight && bus.grant_gen_done;
            t_off = bus.e_sink - BASE;
            t_hit = bus.rx2tx_rcv_tlgntack && (t_off < 26'(NS)) && (t_old[t_off[1:0]] == 2);
            e_acq_ack = t_acc;
            e_gack    = t_hit;
            e_err     = bus.rx2tx_rcv_tlgntack && !t_hit;
            e_tmo     = 1'b0;
`ifdef TL_GNT_TMO_EN
            for (int i = 0; i < NS; i++) begin
                if (t_old[i] == 2 && !(t_hit && int'(t_off[1:0]) == i)) begin
                    if (m_age[i] == TMO - 1) begin m_st[i] = 0; e_tmo = 1'b1; end
                    else m_age[i]++;
                end
            end
`endif
            if (t_hit) m_st[t_off[1:0]] = 0;
            if (t_acc) begin
                m_st[t_pick] = 1;
                e_dsink  = BASE + 26'(t_pick);
                e_dsrc   = bus.a_source;
                e_dparam = (bus.a_param == 3'd0) ? 2'd1 : 2'd0;
                e_gen_en = 1'b1;
                m_inflight = 1'b1;
                m_cur = t_pick;
            end
            m_cool = 1'b0;
            if (t_gd) begin
                m_st[m_cur] = 2; m_age[m_cur] = 0;
                e_gen_en = 1'b0; m_inflight = 1'b0; m_cool = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("acq_ack",    bus.tx2rx_rcv_tlacq_ack,    e_acq_ack);
            chk("gen_en",     bus.grant_gen_en,           e_gen_en);
            chk("d_sink",     bus.d_sink,                 e_dsink);
            chk("d_source",   bus.d_source,               e_dsrc);
            chk("d_param",    bus.d_param,                e_dparam);
            chk("gntack_ack", bus.tx2rx_rcv_tlgntack_ack, e_gack);
            chk("e_sink_err", bus.e_sink_err,             e_err);
            chk("sink_busy",  bus.sink_busy,              m_busy());
            chk("sink_full",  bus.sink_full,              &m_busy());
            chk("tmo_err",    bus.gnt_tmo_err,            e_tmo);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_ack(input int lim, output int n);
        n = 0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (bus.tx2rx_rcv_tlacq_ack) begin n = i; break; end
        end
    endtask

    task automatic do_acq(input logic [25:0] src, input logic [2:0] p, output int n);
        bus.a_source = src; bus.a_param = p; bus.rx2tx_rcv_tlacq = 1'b1;
        wait_ack(20, n);
        chk("acq_seen", (n != 0), 1);
    endtask

    task automatic drop_acq();
        step(); bus.rx2tx_rcv_tlacq = 1'b0;
    endtask

    task automatic gnt(input int dly);
        repeat (dly) step();
        bus.grant_gen_done = 1'b1; step(); bus.grant_gen_done = 1'b0;
    endtask

    task automatic gack(input logic [25:0] s);
        step(); bus.rx2tx_rcv_tlgntack = 1'b1; bus.e_sink = s;
        step(); bus.rx2tx_rcv_tlgntack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [2:0] prm [4];
        logic [1:0] cap [4];
        int n;
        prm = '{3'd0, 3'd1, 3'd2, 3'd5};
        cap = '{2'd1, 2'd0, 2'd0, 2'd0};
        reset = 1'b1;
        bus.rx2tx_rcv_tlacq = 0; bus.a_source = '0; bus.a_param = '0;
        bus.grant_gen_done = 0; bus.rx2tx_rcv_tlgntack = 0; bus.e_sink = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", bus.sink_busy, 4'h0);
        chk("rst_gen_en", bus.grant_gen_en, 0);
        chk("rst_d_sink", bus.d_sink, 26'h0);
        step(); reset = 1'b0;

        // Single Acquire, Grant done 5 clks later, GrantAck retires it.
        do_acq(26'h15, 3'd1, n);
        chk("single_d_sink", bus.d_sink, 26'h100);
        chk("single_d_src", bus.d_source, 26'h15);
        chk("single_d_param", bus.d_param, 2'd0);
        chk("single_busy", bus.sink_busy, 4'b0001);
        drop_acq();
        gnt(5);
        gack(26'h100);
        chk("single_gack", bus.tx2rx_rcv_tlgntack_ack, 1);
        @(negedge clk);
        chk("single_freed", bus.sink_busy, 4'h0);

        // Fill all slots, then a held fifth Acquire waits for a GrantAck.
        for (int i = 0; i < 4; i++) begin
            do_acq(26'h20 + 26'(i), prm[i], n);
            chk("fill_d_sink", bus.d_sink, 26'h100 + 26'(i));
            chk("fill_d_param", bus.d_param, cap[i]);
            drop_acq();
            gnt(1);
        end
        repeat (2) step();
        @(negedge clk);
        chk("fill_busy", bus.sink_busy, 4'hF);
        chk("fill_full", bus.sink_full, 1);
        bus.a_source = 26'h99; bus.a_param = 3'd0; bus.rx2tx_rcv_tlacq = 1'b1;
        wait_ack(8, n);
        chk("fill5_held", n, 0);
        gack(26'h102);
        wait_ack(5, n);
        chk("fill5_acked", (n != 0), 1);
        chk("fill5_d_sink", bus.d_sink, 26'h102);
        chk("fill5_d_param", bus.d_param, 2'd1);
        drop_acq();
        gnt(2);

        // Unmatched GrantAcks: out of range, below base, reserved-not-granted.
        gack(26'h107);
        chk("bad_hi_err", bus.e_sink_err, 1);
        chk("bad_hi_busy", bus.sink_busy, 4'hF);
        gack(26'h0FF);
        chk("bad_lo_err", bus.e_sink_err, 1);
        gack(26'h101);
        chk("free1_ack", bus.tx2rx_rcv_tlgntack_ack, 1);
        do_acq(26'h31, 3'd2, n);
        chk("rsv_d_sink", bus.d_sink, 26'h101);
        drop_acq();
        gack(26'h101);
        chk("rsv_err", bus.e_sink_err, 1);
        chk("rsv_busy", bus.sink_busy, 4'hF);
        gnt(1);

        // GrantAck and Acquire together while full: slot 0 reused a clk later.
        step();
        bus.a_source = 26'h44; bus.a_param = 3'd1; bus.rx2tx_rcv_tlacq = 1'b1;
        bus.rx2tx_rcv_tlgntack = 1'b1; bus.e_sink = 26'h100;
        step(); bus.rx2tx_rcv_tlgntack = 1'b0;
        @(negedge clk);
        chk("sim_gack", bus.tx2rx_rcv_tlgntack_ack, 1);
        chk("sim_no_acq_yet", bus.tx2rx_rcv_tlacq_ack, 0);
        @(negedge clk);
        chk("sim_acq", bus.tx2rx_rcv_tlacq_ack, 1);
        chk("sim_d_sink", bus.d_sink, 26'h100);
        drop_acq();
        gnt(0);

        // Stray grant_gen_done while idle is ignored.
        repeat (3) step();
        bus.grant_gen_done = 1'b1; step(); bus.grant_gen_done = 1'b0;
        @(negedge clk);
        chk("stray_gen_en", bus.grant_gen_en, 0);
        chk("stray_busy", bus.sink_busy, 4'hF);

        // Reset in the middle of a Grant drops everything.
        gack(26'h103);
        do_acq(26'h55, 3'd1, n);
        chk("pre_rst_d_sink", bus.d_sink, 26'h103);
        drop_acq();
        reset = 1'b1; step(); reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_gen_en", bus.grant_gen_en, 0);
        chk("mid_rst_busy", bus.sink_busy, 4'h0);
        do_acq(26'h66, 3'd0, n);
        chk("post_rst_lat", n, 1);
        chk("post_rst_d_sink", bus.d_sink, 26'h100);
        drop_acq();
        gnt(1);
        gack(26'h100);
        chk("post_rst_gack", bus.tx2rx_rcv_tlgntack_ack, 1);

`ifdef TL_GNT_TMO_EN
        do_acq(26'h77, 3'd1, n);
        drop_acq();
        gnt(0);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.gnt_tmo_err) begin n = k; break; end
        end
        chk("tmo_delay", n, 16);
        @(negedge clk);
        chk("tmo_freed", bus.sink_busy, 4'h0);
`endif

        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
